// File: rtl/mem_load_shuffle_ctrl.sv
// Unit-stride load sequencer: counts memory beats, drives the memory shuffler
// controls, gathers shuffled lane data into one block and issues one registered
// all-lane VRF write for each completed block.
module mem_load_shuffle_ctrl #(
    parameter int unsigned NrLane        = 4,
    parameter int unsigned VlWidth       = 16,
    parameter int unsigned VrfAddrWidth  = 10,
    parameter int unsigned VrfWordWidthB = 8,
    localparam int unsigned WordW        = VrfWordWidthB * 8,
    localparam int unsigned ByteCntW     = $clog2(VrfWordWidthB),
    localparam int unsigned SelW         = (NrLane > 1) ? $clog2(NrLane) : 1,
    localparam int unsigned TotW         = VlWidth + 4,
    localparam int unsigned BeatW        = TotW - ByteCntW
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        req_valid_i,
    output logic                                        req_ready_o,
    input  logic [VlWidth-1:0]                          req_vl_i,
    input  logic [1:0]                                  req_sew_i,
    input  logic [ByteCntW-1:0]                         req_offset_i,
    input  logic [VrfAddrWidth-1:0]                     req_vaddr_i,
    input  logic                                        beat_valid_i,
    output logic                                        beat_ready_o,
    input  logic [WordW-1:0]                            beat_data_i,
    output logic [WordW-1:0]                            shuf_data_o,
    output logic [SelW-1:0]                             shuf_sel_o,
    output logic                                        shuf_is_first_o,
    output logic                                        shuf_is_last_o,
    output logic [ByteCntW-1:0]                         shuf_skip_first_o,
    output logic [ByteCntW-1:0]                         shuf_skip_last_o,
    output logic [1:0]                                  shuf_sew_o,
    input  logic [NrLane-1:0][WordW-1:0]                shuf_data_i,
    input  logic [NrLane-1:0][VrfWordWidthB-1:0]        shuf_mask_i,
    output logic                                        wr_valid_o,
    input  logic                                        wr_ready_i,
    output logic [VrfAddrWidth-1:0]                     wr_addr_o,
    output logic [NrLane-1:0][WordW-1:0]                wr_data_o,
    output logic [NrLane-1:0][VrfWordWidthB-1:0]        wr_strb_o,
    output logic                                        done_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain, StDone} state_e;

    state_e                                 state_q, state_d;
    logic [BeatW-1:0]                       beats_q, beats_d;
    logic [BeatW-1:0]                       beat_cnt_q, beat_cnt_d;
    logic [ByteCntW-1:0]                    offset_q, offset_d;
    logic [ByteCntW-1:0]                    skip_last_q, skip_last_d;
    logic [1:0]                             sew_q, sew_d;
    logic [VrfAddrWidth-1:0]                vaddr_q, vaddr_d;
    logic [NrLane-1:0][WordW-1:0]           acc_data_q, acc_data_d;
    logic [NrLane-1:0][VrfWordWidthB-1:0]   acc_strb_q, acc_strb_d;
    logic                                   wr_valid_q, wr_valid_d;
    logic [VrfAddrWidth-1:0]                wr_addr_q, wr_addr_d;
    logic [NrLane-1:0][WordW-1:0]           wr_data_q, wr_data_d;
    logic [NrLane-1:0][VrfWordWidthB-1:0]   wr_strb_q, wr_strb_d;
    logic                                   done_q, done_d;

    logic [TotW-1:0]                        total;
    logic [BeatW-1:0]                       beats_calc;
    logic [ByteCntW-1:0]                    skip_last_calc;
    logic [BeatW-1:0]                       beat_mod;
    logic [SelW-1:0]                        sel;
    logic                                   is_busy, is_first, is_last, completing;
    logic                                   beat_ready, beat_acc, wr_hs;
    logic [NrLane-1:0][WordW-1:0]           merged_data;
    logic [NrLane-1:0][VrfWordWidthB-1:0]   merged_strb;

    // Command beat arithmetic: total bytes, beat count and tail skip.
    always_comb begin
        total          = (TotW'(req_vl_i) << req_sew_i) + TotW'(req_offset_i);
        beats_calc     = total[TotW-1:ByteCntW] + BeatW'(|total[ByteCntW-1:0]);
        skip_last_calc = ByteCntW'(0) - total[ByteCntW-1:0];
    end

    // Per-beat shuffler control and handshake qualification.
    always_comb begin
        is_busy    = (state_q == StBusy);
        beat_mod   = beat_cnt_q % BeatW'(NrLane);
        sel        = SelW'(beat_mod);
        is_first   = (beat_cnt_q == '0);
        is_last    = (beat_cnt_q == beats_q - BeatW'(1));
        completing = (beat_mod == BeatW'(NrLane - 1)) || is_last;
        // A completing beat needs the write register to be free (or freeing now).
        beat_ready = is_busy && (!completing || !wr_valid_q || wr_ready_i);
        beat_acc   = beat_valid_i && beat_ready;
        wr_hs      = wr_valid_q && wr_ready_i;
    end

    // Byte-wise merge of the current shuffler output into the accumulator.
    always_comb begin
        merged_data = acc_data_q;
        merged_strb = acc_strb_q | shuf_mask_i;
        for (int l = 0; l < NrLane; l++) begin
            for (int b = 0; b < VrfWordWidthB; b++) begin
                if (shuf_mask_i[l][b]) begin
                    merged_data[l][8*b +: 8] = shuf_data_i[l][8*b +: 8];
                end
            end
        end
    end

    // Next-state logic for the sequencer FSM, accumulator and write register.
    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        offset_d    = offset_q;
        skip_last_d = skip_last_q;
        sew_d       = sew_q;
        vaddr_d     = vaddr_q;
        acc_data_d  = acc_data_q;
        acc_strb_d  = acc_strb_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
        done_d      = 1'b0;

        if (wr_hs) begin
            wr_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    offset_d    = req_offset_i;
                    sew_d       = req_sew_i;
                    skip_last_d = skip_last_calc;
                    beats_d     = beats_calc;
                    vaddr_d     = req_vaddr_i;
                    beat_cnt_d  = '0;
                    acc_data_d  = '0;
                    acc_strb_d  = '0;
                    if (req_vl_i == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + BeatW'(1);
                    if (completing) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = vaddr_q;
                        wr_data_d  = merged_data;
                        wr_strb_d  = merged_strb;
                        vaddr_d    = vaddr_q + VrfAddrWidth'(1);
                        acc_data_d = '0;
                        acc_strb_d = '0;
                        if (is_last) begin
                            state_d = StDrain;
                        end
                    end else begin
                        acc_data_d = merged_data;
                        acc_strb_d = merged_strb;
                    end
                end
            end
            StDrain: begin
                if (wr_hs) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; a pending write is simply dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            offset_q    <= '0;
            skip_last_q <= '0;
            sew_q       <= '0;
            vaddr_q     <= '0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            offset_q    <= offset_d;
            skip_last_q <= skip_last_d;
            sew_q       <= sew_d;
            vaddr_q     <= vaddr_d;
            acc_data_q  <= acc_data_d;
            acc_strb_q  <= acc_strb_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            done_q      <= done_d;
        end
    end

    assign req_ready_o       = (state_q == StIdle) && !rst_i;
    assign beat_ready_o      = beat_ready;
    assign shuf_data_o       = is_busy ? beat_data_i : '0;
    assign shuf_sel_o        = is_busy ? sel : '0;
    assign shuf_is_first_o   = is_busy && is_first;
    assign shuf_is_last_o    = is_busy && is_last;
    assign shuf_skip_first_o = is_busy ? offset_q : '0;
    assign shuf_skip_last_o  = is_busy ? skip_last_q : '0;
    assign shuf_sew_o        = is_busy ? sew_q : '0;
    assign wr_valid_o        = wr_valid_q;
    assign wr_addr_o         = wr_addr_q;
    assign wr_data_o         = wr_data_q;
    assign wr_strb_o         = wr_strb_q;
    assign done_o            = done_q;

endmodule
